z_pdemux_3_fifo: RTL and testbench



---
 rtl/z_pdemux_3_fifo.sv | 112 +++++++++++
 tb/tb_z_pdemux_3_fifo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/z_pdemux_3_fifo.sv
// Priority demux steering one word stream into three 2-entry FIFO channels,
// with per-channel saturating counts of accepted words.
module z_pdemux_3_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             sel0,
   input  logic             sel1,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out0_valid,
   output logic             out1_valid,
   output logic             out2_valid,
   input  logic             out0_ready,
   input  logic             out1_ready,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic [WIDTH-1:0] out1_data,
   output logic [WIDTH-1:0] out2_data,
   input  logic             count_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2
);

   localparam int unsigned NCH = 3;

   logic [WIDTH-1:0] head_q [NCH];
   logic [WIDTH-1:0] tail_q [NCH];
   logic [1:0]       occ_q  [NCH];
   logic [CNT_W-1:0] cnt_q  [NCH];

   logic [1:0]     dest_c;
   logic [NCH-1:0] push_c;
   logic [NCH-1:0] pop_c;
   logic [NCH-1:0] oready_c;

   assign oready_c = {out2_ready, out1_ready, out0_ready};

   // Same priority encoding as the source mux: sel1 beats sel0
   always_comb begin
      dest_c = 2'd0;
      if (sel1)      dest_c = 2'd2;
      else if (sel0) dest_c = 2'd1;
   end

   // Acceptance depends only on the selected FIFO's occupancy, never on consumer ready
   always_comb begin
      in_ready = 1'b0;
      push_c   = '0;
      pop_c    = '0;
      for (int i = 0; i < NCH; i++) begin
         if (2'(i) == dest_c) in_ready = (occ_q[i] != 2'd2);
      end
      for (int i = 0; i < NCH; i++) begin
         push_c[i] = in_valid && in_ready && (2'(i) == dest_c);
         pop_c[i]  = (occ_q[i] != 2'd0) && oready_c[i];
      end
   end

   // Shift-style FIFO: head_q is always the presented word, tail_q the second entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            occ_q[i]  <= 2'd0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (push_c[i] && pop_c[i]) begin
               head_q[i] <= in_data;
            end else if (push_c[i]) begin
               if (occ_q[i] == 2'd0) head_q[i] <= in_data;
               else                  tail_q[i] <= in_data;
               occ_q[i] <= occ_q[i] + 2'd1;
            end else if (pop_c[i]) begin
               if (occ_q[i] == 2'd2) head_q[i] <= tail_q[i];
               occ_q[i] <= occ_q[i] - 2'd1;
            end
         end
      end
   end

   // Clear wins over a same-cycle increment; counts stick at all-ones
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (count_clr)
               cnt_q[i] <= '0;
            else if (push_c[i] && (cnt_q[i] != {CNT_W{1'b1}}))
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign out0_valid = (occ_q[0] != 2'd0);
   assign out1_valid = (occ_q[1] != 2'd0);
   assign out2_valid = (occ_q[2] != 2'd0);
   assign out0_data  = head_q[0];
   assign out1_data  = head_q[1];
   assign out2_data  = head_q[2];
   assign cnt0       = cnt_q[0];
   assign cnt1       = cnt_q[1];
   assign cnt2       = cnt_q[2];

endmodule

// File: tb/tb_z_pdemux_3_fifo.sv
// Directed bench for z_pdemux_3_fifo: per-channel queue scoreboard plus counter model.
module tb_z_pdemux_3_fifo;

   logic        clock;
   logic        reset_n;
   logic        sel0, sel1, in_valid, in_ready, count_clr;
   logic [11:0] in_data;
   logic        rdy [3];
   logic        ov  [3];
   logic [11:0] od  [3];
   logic [7:0]  oc  [3];

   logic [11:0] q [3][$];
   int          mcnt [3];
   int          n_vec = 0;
   int          n_err = 0;

   z_pdemux_3_fifo #(.WIDTH(12), .CNT_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .sel0(sel0), .sel1(sel1),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out0_valid(ov[0]), .out1_valid(ov[1]), .out2_valid(ov[2]),
      .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]),
      .out0_data(od[0]), .out1_data(od[1]), .out2_data(od[2]),
      .count_clr(count_clr), .cnt0(oc[0]), .cnt1(oc[1]), .cnt2(oc[2])
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int ch = 0; ch < 3; ch++) begin
         chk($sformatf("valid%0d", ch), 32'(ov[ch]), 32'(q[ch].size() > 0));
         if (q[ch].size() > 0) chk($sformatf("head%0d", ch), 32'(od[ch]), 32'(q[ch][0]));
         chk($sformatf("cnt%0d", ch), 32'(oc[ch]), 32'(mcnt[ch]));
      end
   endtask

   task automatic drive(input logic v, input logic s1, input logic s0, input logic [11:0] d,
                        input logic r0, input logic r1, input logic r2, input logic clr);
      in_valid = v; sel1 = s1; sel0 = s0; in_data = d;
      rdy[0] = r0; rdy[1] = r1; rdy[2] = r2; count_clr = clr;
   endtask

   // One clock: check ready and popped heads before the edge, update model, check after
   task automatic tick();
      int dest;
      bit acc;
      bit pop [3];
      #1;
      dest = sel1 ? 2 : (sel0 ? 1 : 0);
      chk("in_ready", 32'(in_ready), 32'(q[dest].size() < 2));
      acc = in_valid && (q[dest].size() < 2);
      for (int ch = 0; ch < 3; ch++) begin
         pop[ch] = (q[ch].size() > 0) && rdy[ch];
         if (pop[ch]) chk($sformatf("pop%0d", ch), 32'(od[ch]), 32'(q[ch][0]));
      end
      @(posedge clock);
      #1;
      for (int ch = 0; ch < 3; ch++) if (pop[ch]) void'(q[ch].pop_front());
      if (acc) q[dest].push_back(in_data);
      for (int ch = 0; ch < 3; ch++) begin
         if (count_clr)                            mcnt[ch] = 0;
         else if (acc && ch == dest && mcnt[ch] < 255) mcnt[ch]++;
      end
      check_all();
   endtask

   initial begin
      for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
      reset_n = 1'b0;
      drive(0, 0, 0, 12'h000, 0, 0, 0, 0);
      #12;
      check_all();
      chk("in_ready_rst", 32'(in_ready), 32'd1);
      reset_n = 1'b1;

      // single word to channel 0
      drive(1, 0, 0, 12'hABC, 0, 0, 0, 0); tick();
      chk("abc_head", 32'(od[0]), 32'hABC);
      drive(0, 0, 0, 12'h000, 1, 0, 0, 0); tick();

      // channel 2 fills at two words, then drains in order
      drive(1, 1, 1, 12'h001, 0, 0, 0, 0); tick();
      drive(1, 1, 1, 12'h002, 0, 0, 0, 0); tick();
      drive(1, 1, 1, 12'h003, 0, 0, 0, 0); tick();
      chk("ch2_head", 32'(od[2]), 32'h001);
      chk("ch2_cnt",  32'(oc[2]), 32'd2);
      drive(1, 1, 1, 12'h003, 0, 0, 1, 0); tick();
      drive(1, 1, 1, 12'h003, 0, 0, 1, 0); tick();
      drive(0, 1, 1, 12'h000, 0, 0, 1, 0); tick();
      drive(0, 1, 1, 12'h000, 0, 0, 1, 0); tick();

      // channel 1 streaming at occupancy 1
      drive(1, 0, 1, 12'h100, 0, 0, 0, 0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 1, 12'(12'h101 + i), 0, 1, 0, 0); tick();
      end
      chk("ch1_cnt", 32'(oc[1]), 32'd11);
      drive(0, 0, 1, 12'h000, 0, 1, 0, 0); tick();

      // channel 0 full, switch selection to channel 1
      drive(1, 0, 0, 12'h200, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 12'h201, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 12'h2FF, 0, 0, 0, 0); tick();
      drive(1, 0, 1, 12'h300, 0, 0, 0, 0); tick();
      chk("ch0_kept", 32'(od[0]), 32'h200);
      chk("ch1_land", 32'(od[1]), 32'h300);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 12'h000, 1, 1, 0, 0); tick();
      end

      // counter saturation, then clear beating a same-cycle push
      for (int i = 0; i < 300; i++) begin
         drive(1, 0, 0, 12'(i), 1, 0, 0, 0); tick();
      end
      chk("cnt0_sat", 32'(oc[0]), 32'd255);
      drive(1, 0, 0, 12'h555, 1, 0, 0, 1); tick();
      chk("cnt0_clr", 32'(oc[0]), 32'd0);
      drive(0, 0, 0, 12'h000, 1, 0, 0, 0); tick();

      // asynchronous reset with channels 0 and 2 full
      drive(1, 0, 0, 12'h400, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 12'h401, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 12'h402, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 12'h403, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 12'h000, 0, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      for (int ch = 0; ch < 3; ch++) begin
         q[ch].delete();
         mcnt[ch] = 0;
      end
      check_all();
      chk("in_ready_arst", 32'(in_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      drive(1, 0, 1, 12'h500, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 12'h501, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 12'h000, 0, 0, 1, 0); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
